// File: rtl/fire_expand_engine_pkg.sv
// Shared types and the output requantiser for the fire expand engine.
package fire_expand_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // ReLU, arithmetic right shift, clamp to the largest positive value of `width` bits.
    function automatic logic [63:0] requant(input logic signed [63:0] sum,
                                            input int shift, input int width);
        logic signed [63:0] q;
        logic signed [63:0] qmax;
        qmax = (64'sd1 <<< (width - 1)) - 64'sd1;
        q    = sum >>> shift;
        if (sum < 0)   return '0;
        if (q > qmax)  return qmax;
        return q;
    endfunction

endpackage

// File: rtl/fire_expand_engine_if.sv
// Pixel stream, weight ROM, bias and output-vector bus of the expand engine.
interface fire_expand_engine_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int DSP_NO    = 128,
    parameter int AW        = 9
);
    logic [WIDTH-1:0]                  ifm_i;
    logic                              ifm_valid_i;
    logic                              ifm_ready_o;
    logic [AW-1:0]                     weight_rom_address_o;
    logic [DSP_NO-1:0][WIDTH-1:0]      kernels_i;
    logic [DSP_NO-1:0][ACC_WIDTH-1:0]  bias_i;
    logic [DSP_NO-1:0][WIDTH-1:0]      ofm_o;
    logic                              ofm_valid_o;

    modport master (
        input  ifm_i, ifm_valid_i, kernels_i, bias_i,
        output ifm_ready_o, weight_rom_address_o, ofm_o, ofm_valid_o
    );
    modport slave (
        output ifm_i, ifm_valid_i, kernels_i, bias_i,
        input  ifm_ready_o, weight_rom_address_o, ofm_o, ofm_valid_o
    );
endinterface

// File: rtl/fire_expand_engine_mac_lane.sv
// One output-channel MAC: restarts on the first tap of a pixel, holds on bubbles.
module mac_lane #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        first,
    input  logic signed [WIDTH-1:0]     pix,
    input  logic signed [WIDTH-1:0]     ker,
    output logic signed [ACC_WIDTH-1:0] acc
);
    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] base;

    assign prod = pix * ker;
    assign base = first ? '0 : acc;

    always_ff @(posedge clk) begin
        if (rst)     acc <= '0;
        else if (en) acc <= base + ACC_WIDTH'(prod);
    end
endmodule

// File: rtl/fire_expand_engine.sv
// Generic fire expand-layer engine: streams taps, MACs DSP_NO channels in parallel,
// then bias + ReLU + saturating requantise into one output vector per pixel.
module fire_expand_engine
    import fire_expand_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int DSP_NO     = 128,
    parameter int CHIN       = 32,
    parameter int KERNEL_DIM = 3,
    parameter int WOUT       = 32,
    parameter int FRAC_SHIFT = 14,
    parameter int LAYERS     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic [(LAYERS > 1 ? $clog2(LAYERS) : 1)-1:0] layer_sel_i,
    output logic [(LAYERS > 1 ? $clog2(LAYERS) : 1)-1:0] layer_sel_o,
    output logic busy_o,
    output logic done_o,
    input  logic ram_feedback_i,
    fire_expand_engine_if.master bus
);
    localparam int TAPS = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int NPIX = WOUT * WOUT;
    localparam int TW   = TAPS > 1 ? $clog2(TAPS) : 1;
    localparam int PW   = NPIX > 1 ? $clog2(NPIX) : 1;

    state_t                        state, state_nx;
    logic [TW-1:0]                 tap_cnt;
    logic [PW-1:0]                 pix_cnt;
    logic                          accept, tap_last, last_beat, strobe;
    logic [1:0]                    vld_pipe, last_pipe;
    logic                          s1_first;
    logic signed [WIDTH-1:0]       s1_pix;
    logic [DSP_NO-1:0][WIDTH-1:0]  s1_ker, ofm_nx;

    assign accept    = (state == RUN) && bus.ifm_valid_i;
    assign tap_last  = tap_cnt == TW'(TAPS - 1);
    assign last_beat = accept && tap_last && (pix_cnt == PW'(NPIX - 1));
    assign strobe    = vld_pipe[1] && last_pipe[1];

    assign bus.ifm_ready_o          = state == RUN;
    assign bus.weight_rom_address_o = tap_cnt;
    assign busy_o                   = state != IDLE;
    assign done_o                   = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start_i)          state_nx = RUN;
            RUN:   if (last_beat)        state_nx = DRAIN;
            DRAIN: if (vld_pipe == '0)   state_nx = DONE;
            DONE:  if (ram_feedback_i)   state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt     <= '0;
            pix_cnt     <= '0;
            layer_sel_o <= '0;
        end else if (state == IDLE && start_i) begin
            tap_cnt     <= '0;
            pix_cnt     <= '0;
            layer_sel_o <= layer_sel_i;
        end else if (accept) begin
            if (tap_last) begin
                tap_cnt <= '0;
                pix_cnt <= (pix_cnt == PW'(NPIX - 1)) ? '0 : pix_cnt + 1'b1;
            end else begin
                tap_cnt <= tap_cnt + 1'b1;
            end
        end
    end

    // S1: last_pipe tracks every cycle and is only meaningful alongside vld_pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            s1_first  <= 1'b0;
            s1_pix    <= '0;
            s1_ker    <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[0], accept};
            last_pipe <= {last_pipe[0], tap_last};
            if (accept) begin
                s1_first <= tap_cnt == '0;
                s1_pix   <= signed'(bus.ifm_i);
                s1_ker   <= bus.kernels_i;
            end
        end
    end

    for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] acc, sum;

        mac_lane #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
            .clk   (clk),
            .rst   (rst),
            .en    (vld_pipe[0]),
            .first (s1_first),
            .pix   (s1_pix),
            .ker   (s1_ker[l]),
            .acc   (acc)
        );

        assign sum       = acc + signed'(bus.bias_i[l]);
        assign ofm_nx[l] = WIDTH'(requant(64'(sum), FRAC_SHIFT, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ofm_o       <= '0;
            bus.ofm_valid_o <= 1'b0;
        end else begin
            bus.ofm_valid_o <= strobe;
            if (strobe) bus.ofm_o <= ofm_nx;
        end
    end
endmodule

// File: tb/tb_fire_expand_engine.sv
// Bench for fire_expand_engine in a 2-lane 1x1 config, with FRAC_SHIFT 0 and 14 side by side.
module tb_fire_expand_engine;
    localparam int WIDTH = 16, ACC = 32, DSP = 2, CHIN = 2, KD = 1, WOUT = 2, LAYERS = 2;
    localparam int TAPS = KD * KD * CHIN, NPIX = WOUT * WOUT, AW = 1;

    typedef struct {
        int          cyc;
        logic [15:0] v0;
        logic [15:0] v1;
        logic        done;
    } strobe_t;

    logic clk = 1'b0;
    logic rst, start, lsel_in, ack, ifm_valid;
    logic [WIDTH-1:0] ifm;
    logic [0:0] lsel0, lsel1;
    logic busy0, busy1, done0, done1;
    int cyc = 0;
    int nvec = 0, nerr = 0;

    logic signed [15:0] pix [NPIX][TAPS];
    logic signed [15:0] rom [LAYERS][TAPS][DSP];
    logic signed [31:0] bias_m [LAYERS][DSP];
    int exp_cyc [NPIX];
    strobe_t q0[$], q1[$];

    fire_expand_engine_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC), .DSP_NO(DSP), .AW(AW)) bus0 ();
    fire_expand_engine_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC), .DSP_NO(DSP), .AW(AW)) bus1 ();

    fire_expand_engine #(.WIDTH(WIDTH), .ACC_WIDTH(ACC), .DSP_NO(DSP), .CHIN(CHIN),
        .KERNEL_DIM(KD), .WOUT(WOUT), .FRAC_SHIFT(0), .LAYERS(LAYERS)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .layer_sel_i(lsel_in), .layer_sel_o(lsel0),
        .busy_o(busy0), .done_o(done0), .ram_feedback_i(ack), .bus(bus0));

    fire_expand_engine #(.WIDTH(WIDTH), .ACC_WIDTH(ACC), .DSP_NO(DSP), .CHIN(CHIN),
        .KERNEL_DIM(KD), .WOUT(WOUT), .FRAC_SHIFT(14), .LAYERS(LAYERS)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .layer_sel_i(lsel_in), .layer_sel_o(lsel1),
        .busy_o(busy1), .done_o(done1), .ram_feedback_i(ack), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus0.ifm_i = ifm;
    assign bus1.ifm_i = ifm;
    assign bus0.ifm_valid_i = ifm_valid;
    assign bus1.ifm_valid_i = ifm_valid;

    // Weight ROM and bias bank, addressed by each engine's own outputs.
    always_comb begin
        for (int l = 0; l < DSP; l++) begin
            bus0.kernels_i[l] = rom[lsel0][bus0.weight_rom_address_o][l];
            bus1.kernels_i[l] = rom[lsel1][bus1.weight_rom_address_o][l];
            bus0.bias_i[l]    = bias_m[lsel0][l];
            bus1.bias_i[l]    = bias_m[lsel1][l];
        end
    end

    always @(negedge clk) begin
        if (bus0.ofm_valid_o === 1'b1) q0.push_back('{cyc, bus0.ofm_o[0], bus0.ofm_o[1], done0});
        if (bus1.ofm_valid_o === 1'b1) q1.push_back('{cyc, bus1.ofm_o[0], bus1.ofm_o[1], done1});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_q(input int sum, input int sh);
        longint q;
        if (sum < 0) return 16'd0;
        q = longint'(sum) / (longint'(1) << sh);
        if (q > 32767) return 16'd32767;
        return q[15:0];
    endfunction

    // Expected output: dot product of the pixel's taps with the layer's weights, plus bias.
    function automatic logic [15:0] model(input int L, input int p, input int l, input int sh);
        int acc = 0;
        for (int t = 0; t < TAPS; t++) acc += int'(pix[p][t]) * int'(rom[L][t][l]);
        return ref_q(acc + int'(bias_m[L][l]), sh);
    endfunction

    function automatic logic signed [15:0] rnd16();
        int v;
        if ($urandom_range(1, 0) == 0) return 16'($urandom);
        v = int'($urandom_range(600, 0)) - 300;
        return 16'(v);
    endfunction

    task automatic randomize_all();
        for (int L = 0; L < LAYERS; L++)
            for (int l = 0; l < DSP; l++) begin
                bias_m[L][l] = ($urandom_range(3, 0) == 0) ? 32'($urandom)
                                                           : 32'(int'($urandom_range(4000, 0)) - 2000);
                for (int t = 0; t < TAPS; t++) rom[L][t][l] = rnd16();
            end
        for (int p = 0; p < NPIX; p++)
            for (int t = 0; t < TAPS; t++) pix[p][t] = rnd16();
    endtask

    task automatic run_layer(input int L, input int stall_max, input bit junk);
        int n, k;
        q0.delete();
        q1.delete();
        @(negedge clk); start = 1'b1; lsel_in = L[0];
        @(negedge clk); start = 1'b0;
        chk("busy_run", busy0, 1);
        chk("ready_run", bus0.ifm_ready_o, 1);
        for (int p = 0; p < NPIX; p++)
            for (int t = 0; t < TAPS; t++) begin
                n = $urandom_range(stall_max, 0);
                repeat (n) begin
                    ifm_valid = 1'b0;
                    ifm       = 16'($urandom);
                    lsel_in   = 1'($urandom);
                    start     = junk & 1'($urandom);
                    @(negedge clk);
                    chk("addr_hold", bus0.weight_rom_address_o, t);
                end
                start = 1'b0;
                chk("addr", bus0.weight_rom_address_o, t);
                chk("lsel0", lsel0, L);
                chk("lsel1", lsel1, L);
                ifm_valid = 1'b1;
                ifm       = pix[p][t];
                if (t == TAPS - 1) exp_cyc[p] = cyc + 3;
                @(negedge clk);
            end
        ifm_valid = 1'b0;
        k = 0;
        while (done0 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("done0", done0, 1);
        chk("done1", done1, 1);
        chk("nstrobe0", q0.size(), NPIX);
        chk("nstrobe1", q1.size(), NPIX);
        for (int p = 0; p < NPIX; p++) begin
            if (p < q0.size()) begin
                chk("strobe_cyc", q0[p].cyc, exp_cyc[p]);
                chk("ofm0_l0", q0[p].v0, model(L, p, 0, 0));
                chk("ofm0_l1", q0[p].v1, model(L, p, 1, 0));
                chk("done_early", q0[p].done, 0);
            end
            if (p < q1.size()) begin
                chk("ofm1_l0", q1[p].v0, model(L, p, 0, 14));
                chk("ofm1_l1", q1[p].v1, model(L, p, 1, 14));
            end
        end
        repeat ($urandom_range(3, 1)) begin
            start = 1'($urandom);
            @(negedge clk);
            chk("done_hold", done0, 1);
            chk("ready_done", bus0.ifm_ready_o, 0);
        end
        ack = 1'b1; start = 1'b1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        chk("done_clr", done0, 0);
        chk("idle_after_ack", busy0, 0);
        chk("lsel_kept", lsel0, L);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; lsel_in = 1'b1; ack = 1'b0; ifm_valid = 1'b0; ifm = '0;
        randomize_all();
        repeat (3) @(negedge clk);
        chk("rst_ofm", bus0.ofm_o, 0);
        chk("rst_vld", bus0.ofm_valid_o, 0);
        chk("rst_done", done0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_ready", bus0.ifm_ready_o, 0);
        chk("rst_addr", bus0.weight_rom_address_o, 0);
        chk("rst_lsel", lsel0, 0);
        rst = 1'b0; start = 1'b0;

        // Basic: 3*2 + 4*5 + 4 = 30 on lane 0, lane 1 negative so ReLU gives 0.
        rom[0][0][0] = 16'sd2;  rom[0][1][0] = 16'sd5;
        rom[0][0][1] = -16'sd3; rom[0][1][1] = -16'sd5;
        bias_m[0][0] = 32'sd4;  bias_m[0][1] = 32'sd0;
        pix[0][0] = 16'sd3; pix[0][1] = 16'sd4;
        run_layer(0, 0, 1'b0);
        if (q0.size() > 0) begin
            chk("basic_lane0", q0[0].v0, 30);
            chk("basic_relu", q0[0].v1, 0);
        end

        // Same data with bubbles and stray start pulses.
        run_layer(0, 5, 1'b1);
        if (q0.size() > 0) chk("stall_lane0", q0[0].v0, 30);

        // Saturation on layer 1: 38400 and 49152 clamp to 32767; >>14 gives 3 for 49152.
        rom[1][0][0] = 16'sd200; rom[1][1][0] = 16'sd0;
        rom[1][0][1] = 16'sd256; rom[1][1][1] = 16'sd0;
        bias_m[1][0] = 32'sd0;   bias_m[1][1] = 32'sd0;
        pix[0][0] = 16'sd192;
        run_layer(1, 2, 1'b1);
        if (q0.size() > 0) begin
            chk("sat_lane0", q0[0].v0, 32767);
            chk("sat_lane1", q0[0].v1, 32767);
        end
        if (q1.size() > 0) chk("shift14_lane1", q1[0].v1, 3);

        // Reset after 3 beats must abort without a strobe.
        pix[0][0] = 16'sd3; pix[0][1] = 16'sd4;
        @(negedge clk); start = 1'b1; lsel_in = 1'b0;
        @(negedge clk); start = 1'b0;
        q0.delete(); q1.delete();
        for (int b = 0; b < 3; b++) begin
            ifm_valid = 1'b1; ifm = pix[b / TAPS][b % TAPS];
            @(negedge clk);
        end
        ifm_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_nostrobe", q0.size() + q1.size(), 0);
        chk("abort_idle", busy0, 0);
        chk("abort_addr", bus0.weight_rom_address_o, 0);
        run_layer(0, 1, 1'b0);
        if (q0.size() > 0) chk("post_abort_lane0", q0[0].v0, 30);

        for (int it = 0; it < 6; it++) begin
            randomize_all();
            run_layer(int'($urandom_range(1, 0)), 3, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
